// File: rtl/sound_pkg.sv
// rtl/sound_pkg.sv - shared sample/address widths and echo FSM states
package sound_pkg;
  localparam int SAMPLE_W_DEF = 24;
  localparam int ADDR_W_DEF   = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WT   = 2'd2,
    WR   = 2'd3
  } echo_state_e;
endpackage

// File: rtl/echo_mix.sv
// rtl/echo_mix.sv - combinational dry/wet mixer
// Halving each operand before summing keeps the result inside SAMPLE_W.
module echo_mix
  import sound_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                on_i,
  input  logic [SAMPLE_W-1:0] dry_i,
  input  logic [SAMPLE_W-1:0] wet_i,
  output logic [SAMPLE_W-1:0] mix_o
);
  logic signed [SAMPLE_W-1:0] half_dry;
  logic signed [SAMPLE_W-1:0] half_wet;

  always_comb begin
    half_dry = $signed(dry_i) >>> 1;
    half_wet = $signed(wet_i) >>> 1;
    if (on_i) mix_o = SAMPLE_W'(half_dry + half_wet);
    else      mix_o = dry_i;
  end
endmodule

// File: rtl/echo_ctrl.sv
// rtl/echo_ctrl.sv - echo controller driving an external single-port delay RAM
// One sample per IDLE->RD->WT->WR pass: read the delayed tap, then write the new sample.
module echo_ctrl
  import sound_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] in_data,
  input  logic                wren,
  input  logic                on,
  input  logic [ADDR_W-1:0]   cfg_delay,
  input  logic                cfg_load,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [SAMPLE_W-1:0] mem_wdata,
  input  logic [SAMPLE_W-1:0] mem_rdata,
  output logic [SAMPLE_W-1:0] out_data,
  output logic                out_valid,
  output logic                overrun
);
  localparam logic [ADDR_W:0] FILL_MAX = {1'b1, {ADDR_W{1'b0}}};

  echo_state_e         state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   delay_q, delay_d;
  logic [ADDR_W-1:0]   pend_q, pend_d;
  logic                pend_vld_q, pend_vld_d;
  logic [ADDR_W:0]     fill_q, fill_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic [SAMPLE_W-1:0] delayed_q, delayed_d;
  logic [SAMPLE_W-1:0] out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                overrun_q, overrun_d;
  logic [ADDR_W:0]     eff_delay;
  logic [SAMPLE_W-1:0] mix;

  // A zero delay code means the full memory depth.
  assign eff_delay = {delay_q == '0, delay_q};

  echo_mix #(.SAMPLE_W(SAMPLE_W)) u_mix (
    .on_i  (on),
    .dry_i (sample_q),
    .wet_i (delayed_q),
    .mix_o (mix)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      delay_q     <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      fill_q      <= '0;
      sample_q    <= '0;
      delayed_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      delay_q     <= delay_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      fill_q      <= fill_d;
      sample_q    <= sample_d;
      delayed_q   <= delayed_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    delay_d     = delay_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    fill_d      = fill_q;
    sample_d    = sample_q;
    delayed_d   = delayed_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q;
    mem_addr    = wr_ptr_q;
    mem_we      = 1'b0;
    mem_wdata   = '0;

    if (cfg_load) begin
      pend_d     = cfg_delay;
      pend_vld_d = 1'b1;
    end
    if (wren && state_q != IDLE) overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (wren) begin
          sample_d = in_data;
          state_d  = RD;
          // A same-cycle load takes effect on this very sample.
          if (cfg_load) begin
            delay_d    = cfg_delay;
            fill_d     = '0;
            pend_vld_d = 1'b0;
          end else if (pend_vld_q) begin
            delay_d    = pend_q;
            fill_d     = '0;
            pend_vld_d = 1'b0;
          end
        end
      end
      RD: begin
        mem_addr = wr_ptr_q - delay_q;
        state_d  = WT;
      end
      WT: begin
        delayed_d = (fill_q < eff_delay) ? '0 : mem_rdata;
        state_d   = WR;
      end
      WR: begin
        mem_we      = 1'b1;
        mem_wdata   = sample_q;
        wr_ptr_d    = wr_ptr_q + 1'b1;
        out_data_d  = mix;
        out_valid_d = 1'b1;
        if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_echo_ctrl.sv
// tb/tb_echo_ctrl.sv - directed self-checking bench for echo_ctrl
module tb_echo_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] in_data;
  logic        wren;
  logic        on;
  logic [11:0] cfg_delay;
  logic        cfg_load;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata;
  logic [23:0] out_data;
  logic        out_valid;
  logic        overrun;

  logic [23:0] ram [4096];
  int n_chk = 0;
  int n_fail = 0;

  echo_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .wren      (wren),
    .on        (on),
    .cfg_delay (cfg_delay),
    .cfg_load  (cfg_load),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic run_sample(input logic [23:0] d, input logic ld,
                            output logic [23:0] od, output logic [11:0] waddr,
                            output logic [23:0] wdata, output int vc,
                            output int nv, output int nwe);
    in_data  = d;
    wren     = 1'b1;
    cfg_load = ld;
    tick();
    wren     = 1'b0;
    cfg_load = 1'b0;
    od = '0; waddr = '0; wdata = '0; vc = -1; nv = 0; nwe = 0;
    for (int k = 1; k <= 6; k++) begin
      if (mem_we) begin nwe++; waddr = mem_addr; wdata = mem_wdata; end
      if (out_valid) begin nv++; if (vc < 0) vc = k; od = out_data; end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    n_chk++; if (out_data !== 24'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 000000", out_data); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_chk++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    n_chk++; if (mem_addr !== 12'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 000", mem_addr); end
    n_chk++; if (mem_wdata !== 24'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 000000", mem_wdata); end
    n_chk++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_delay();
    logic [23:0] vin [4]  = '{24'h200000, 24'h000000, 24'h000000, 24'h000000};
    logic [23:0] vexp [4] = '{24'h100000, 24'h000000, 24'h000000, 24'h100000};
    logic [23:0] od, wd;
    logic [11:0] wa;
    int vc, nv, nwe;
    do_reset();
    on = 1'b1;
    cfg_delay = 12'd3;
    for (int i = 0; i < 4; i++) begin
      run_sample(vin[i], i == 0, od, wa, wd, vc, nv, nwe);
      n_chk++; if (wa !== 12'(i) || nwe != 1) begin n_fail++; $display("FAIL delay_waddr[%0d]: got %h (%0d writes) want %h", i, wa, nwe, 12'(i)); end
      n_chk++; if (od !== vexp[i] || nv != 1) begin n_fail++; $display("FAIL delay_out[%0d]: got %h (%0d valids) want %h", i, od, nv, vexp[i]); end
    end
  endtask

  task automatic test_first_sample();
    logic [23:0] od, wd;
    logic [11:0] wa;
    int vc, nv, nwe;
    do_reset();
    on = 1'b1;
    run_sample(24'h100000, 1'b0, od, wa, wd, vc, nv, nwe);
    n_chk++; if (vc != 4 || nv != 1) begin n_fail++; $display("FAIL first_latency: got cycle %0d count %0d want cycle 4 count 1", vc, nv); end
    n_chk++; if (od !== 24'h080000) begin n_fail++; $display("FAIL first_out: got %h want 080000", od); end
    n_chk++; if (wa !== 12'h0 || wd !== 24'h100000) begin n_fail++; $display("FAIL first_write: got %h@%h want 100000@000", wd, wa); end
  endtask

  task automatic test_sign();
    logic [23:0] od, wd;
    logic [11:0] wa;
    int vc, nv, nwe;
    do_reset();
    on = 1'b1;
    cfg_delay = 12'd1;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    run_sample(24'hFFFFFE, 1'b0, od, wa, wd, vc, nv, nwe);
    n_chk++; if (od !== 24'hFFFFFF) begin n_fail++; $display("FAIL sign_first: got %h want ffffff", od); end
    run_sample(24'hFFFFFC, 1'b0, od, wa, wd, vc, nv, nwe);
    n_chk++; if (od !== 24'hFFFFFD || vc != 4) begin n_fail++; $display("FAIL sign_mix: got %h at cycle %0d want fffffd at 4", od, vc); end
  endtask

  task automatic test_dry();
    logic [23:0] od, wd;
    logic [11:0] wa;
    int vc, nv, nwe;
    on = 1'b0;
    run_sample(24'h800001, 1'b0, od, wa, wd, vc, nv, nwe);
    n_chk++; if (od !== 24'h800001) begin n_fail++; $display("FAIL dry_pass: got %h want 800001", od); end
  endtask

  task automatic test_overrun();
    logic [23:0] od, wd;
    logic [11:0] wa;
    int vc, nv, nwe;
    do_reset();
    on = 1'b0;
    in_data = 24'h0ABCDE;
    wren = 1'b1;
    tick();
    wren = 1'b0;
    tick();
    in_data = 24'h555555;
    wren = 1'b1;
    tick();
    wren = 1'b0;
    nv = 0; od = '0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) begin nv++; od = out_data; end
      tick();
    end
    n_chk++; if (nv != 1 || od !== 24'h0ABCDE) begin n_fail++; $display("FAIL overrun_inflight: got %h (%0d valids) want 0abcde (1)", od, nv); end
    n_chk++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b want 1", overrun); end
    run_sample(24'h000777, 1'b0, od, wa, wd, vc, nv, nwe);
    n_chk++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
    n_chk++; if (od !== 24'h000777 || wa !== 12'h1) begin n_fail++; $display("FAIL overrun_next: got %h@%h want 000777@001", od, wa); end
  endtask

  task automatic test_reset_mid();
    int n_bad;
    in_data = 24'h123456;
    wren = 1'b1;
    tick();
    wren = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    n_chk++; if (out_data !== 24'h0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out: got %h/%b want 000000/0", out_data, out_valid); end
    n_chk++; if (mem_we !== 1'b0 || mem_addr !== 12'h0 || mem_wdata !== 24'h0) begin n_fail++; $display("FAIL mid_mem: got we %b addr %h wdata %h want 0/000/000000", mem_we, mem_addr, mem_wdata); end
    n_chk++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL mid_overrun: got %b want 0", overrun); end
    tick();
    reset = 1'b1;
    n_bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (mem_we || out_valid) n_bad++;
      tick();
    end
    n_chk++; if (n_bad != 0) begin n_fail++; $display("FAIL mid_abort: got %0d active cycles want 0", n_bad); end
  endtask

  task automatic test_wrap();
    logic [23:0] od, wd;
    logic [11:0] wa;
    int vc, nv, nwe;
    do_reset();
    on = 1'b1;
    for (int k = 1; k <= 4096; k++) begin
      in_data = 24'(32'h100 + k);
      wren = 1'b1;
      tick();
      wren = 1'b0;
      tick();
      tick();
      tick();
    end
    n_chk++; if (out_valid !== 1'b1 || out_data !== 24'h000880) begin n_fail++; $display("FAIL wrap_last_fill: got %h/%b want 000880/1", out_data, out_valid); end
    run_sample(24'h001101, 1'b0, od, wa, wd, vc, nv, nwe);
    n_chk++; if (wa !== 12'h0) begin n_fail++; $display("FAIL wrap_addr: got %h want 000", wa); end
    n_chk++; if (od !== 24'h000900) begin n_fail++; $display("FAIL wrap_mix: got %h want 000900", od); end
  endtask

  initial begin
    reset = 1'b0; in_data = '0; wren = 1'b0; on = 1'b0;
    cfg_delay = '0; cfg_load = 1'b0;
    test_reset();
    test_delay();
    test_first_sample();
    test_sign();
    test_dry();
    test_overrun();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
